// File: rtl/bcd_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// Each iteration shifts right one bit, then takes 3 off any BCD nibble >= 8.
module bcd_bin #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic [BIN_W-1:0]      binary,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t             state_q, state_d;
   logic [SR_W-1:0]    sr_q, sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIN_W-1:0]   binary_q, binary_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;

   logic [SR_W-1:0]    sr_adj;
   logic               bad_digit;
   logic               last_iter;

   // One iteration: shift, then correct every BCD nibble in parallel.
   always_comb begin
      sr_adj = sr_q >> 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (sr_adj[BIN_W+4*i +: 4] >= 4'd8)
            sr_adj[BIN_W+4*i +: 4] = sr_adj[BIN_W+4*i +: 4] - 4'd3;
      end
   end

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end

   assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      binary_d = binary_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      error_d  = error_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (bad_digit) begin
                  binary_d = '0;
                  error_d  = 1'b1;
                  done_d   = 1'b1;
               end else begin
                  sr_d    = {bcd_in, {BIN_W{1'b0}}};
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            sr_d  = sr_adj;
            cnt_d = cnt_q + 1'b1;
            if (last_iter) begin
               binary_d = sr_adj[BIN_W-1:0];
               error_d  = 1'b0;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sr_q     <= '0;
         cnt_q    <= '0;
         binary_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         binary_q <= binary_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   assign binary = binary_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign error  = error_q;

   // A valid input must have drained the BCD field completely.
   a_residue_zero: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == S_SHIFT && last_iter) |-> (sr_adj[SR_W-1:BIN_W] == '0));

endmodule
